// File: rtl/isa_pkg.sv
// Shared ISA definitions for the fetch front-end: opcode constants, common
// types and the fetch FSM state encoding.
package isa_pkg;

    localparam logic [3:0] OPC_LABEL     = 4'hF;
    localparam logic [3:0] OPC_JMP       = 4'h7;
    localparam logic [3:0] OPC_BEQ0      = 4'h6;
    localparam logic [7:0] INSTR_HALT    = 8'hE0;
    localparam logic [7:0] INSTR_ILLEGAL = 8'hFF;

    typedef logic [3:0] label_idx_t;
    typedef logic [7:0] addr_t;
    typedef logic [7:0] instr_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        RUN,
        HALTED
    } fetch_state_e;

    // Label index 15 shares its encoding with the illegal opcode, so it never names a label.
    function automatic logic is_label(instr_t ins);
        return (ins[7:4] == OPC_LABEL) && (ins[3:0] != 4'hF);
    endfunction

    function automatic logic is_stop(instr_t ins);
        return (ins == INSTR_HALT) || (ins == INSTR_ILLEGAL);
    endfunction

endpackage

// File: rtl/label_table.sv
// Label address table: one write port used during the pre-scan, one
// asynchronous read port used by redirects, and a synchronous valid clear.
module label_table #(
    parameter int ADDR_W     = 8,
    parameter int NUM_LABELS = 16,
    parameter int IDX_W      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid
);

    logic [ADDR_W-1:0]     addrs [NUM_LABELS];
    logic [NUM_LABELS-1:0] valid;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    // Address storage needs no reset: an entry is only read while its valid bit is set.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            addrs[wr_idx] <= wr_addr;
        end
    end

    assign rd_addr  = addrs[rd_idx];
    assign rd_valid = valid[rd_idx];

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch front-end: pre-scans a program for label markers, then
// streams instructions to the decoder with stall, redirect and halt handling.
module inst_fetch_unit
    import isa_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int INSTR_W    = 8,
    parameter int NUM_LABELS = 16
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          start_i,
    input  logic [ADDR_W-1:0]             prog_base_i,
    output logic [ADDR_W-1:0]             address_o,
    input  logic [INSTR_W-1:0]            instruction_i,
    output logic [INSTR_W-1:0]            instr_o,
    output logic                          instr_valid_o,
    output logic [ADDR_W-1:0]             pc_o,
    input  logic                          stall_i,
    input  logic                          redirect_i,
    input  logic [$clog2(NUM_LABELS)-1:0] label_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          error_o
);

    localparam int LBL_W = $clog2(NUM_LABELS);

    fetch_state_e      state;
    logic [ADDR_W-1:0] fptr;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] fptr_inc;
    logic [ADDR_W-1:0] tbl_addr;
    logic              tbl_valid;
    logic              tbl_wr;
    logic              accept_start;
    logic              scan_last;
    logic              halt_out;

    assign fptr_inc     = fptr + ADDR_W'(1);
    assign address_o    = fptr;
    assign busy_o       = (state == SCAN) || (state == RUN);
    assign accept_start = start_i && ((state == IDLE) || (state == HALTED));
    assign tbl_wr       = (state == SCAN) && is_label(instruction_i);

    // Scan stops on a terminator or once every address from the base has been read.
    assign scan_last = is_stop(instruction_i) || (fptr_inc == base_q);

    // A halt already sitting valid on the decoder output retires the program.
    assign halt_out = instr_valid_o && is_stop(instr_o);

    label_table #(
        .ADDR_W     (ADDR_W),
        .NUM_LABELS (NUM_LABELS),
        .IDX_W      (LBL_W)
    ) u_labels (
        .clk      (clk_i),
        .rst      (reset_i),
        .clr      (accept_start),
        .wr_en    (tbl_wr),
        .wr_idx   (instruction_i[LBL_W-1:0]),
        .wr_addr  (fptr),
        .rd_idx   (label_i),
        .rd_addr  (tbl_addr),
        .rd_valid (tbl_valid)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state         <= IDLE;
            fptr          <= '0;
            base_q        <= '0;
            instr_o       <= '0;
            pc_o          <= '0;
            instr_valid_o <= 1'b0;
            done_o        <= 1'b0;
            error_o       <= 1'b0;
        end else begin
            case (state)
                IDLE, HALTED: begin
                    if (start_i) begin
                        fptr          <= prog_base_i;
                        base_q        <= prog_base_i;
                        instr_valid_o <= 1'b0;
                        done_o        <= 1'b0;
                        error_o       <= 1'b0;
                        state         <= SCAN;
                    end
                end
                SCAN: begin
                    if (scan_last) begin
                        fptr  <= base_q;
                        state <= RUN;
                    end else begin
                        fptr <= fptr_inc;
                    end
                end
                RUN: begin
                    if (halt_out) begin
                        state         <= HALTED;
                        done_o        <= 1'b1;
                        instr_valid_o <= 1'b0;
                        if (instr_o == INSTR_ILLEGAL) begin
                            error_o <= 1'b1;
                        end
                    end else if (redirect_i) begin
                        // The redirect cycle is squashed whether or not the label exists.
                        instr_valid_o <= 1'b0;
                        if (tbl_valid) begin
                            fptr <= tbl_addr;
                        end else begin
                            error_o <= 1'b1;
                            state   <= HALTED;
                        end
                    end else if (!stall_i) begin
                        instr_o       <= instruction_i;
                        pc_o          <= fptr;
                        instr_valid_o <= 1'b1;
                        fptr          <= fptr_inc;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
